// File: rtl/i2s_clock_controller_if.sv
// Control/status bundle between the I2S clock sequencer and its user.
// The sequencer side is the master: it takes enable and drives the bus clocks and status.
interface i2s_clock_controller_if;
    logic enable;
    logic sck;
    logic ws;
    logic frame_start;
    logic running;
    logic busy;

    modport master (
        input  enable,
        output sck,
        output ws,
        output frame_start,
        output running,
        output busy
    );

    modport slave (
        output enable,
        input  sck,
        input  ws,
        input  frame_start,
        input  running,
        input  busy
    );
endinterface

// File: rtl/i2s_clock_controller.sv
// Primary-side I2S bit-clock / word-select sequencer with mic start-up hold-off
// and a clean stop on the next frame boundary.
module i2s_clock_controller #(
    parameter int SCK_DIV     = 16,
    parameter int SLOT_BITS   = 32,
    parameter int STARTUP_SCK = 262144
) (
    input  logic                         m_axis_aclk,
    input  logic                         m_axis_aresetn,
    i2s_clock_controller_if.master       bus
);
    localparam int DW = $clog2(SCK_DIV);
    localparam int BW = $clog2(SLOT_BITS);
    localparam int SW = $clog2(STARTUP_SCK + 1);

    localparam logic [DW-1:0] DCNT_MAX = DW'(SCK_DIV - 1);
    localparam logic [BW-1:0] BCNT_MAX = BW'(SLOT_BITS - 1);
    localparam logic [SW-1:0] SCNT_MAX = SW'(STARTUP_SCK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STARTUP = 2'd1,
        RUN     = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t        state;
    logic [DW-1:0] dcnt;
    logic [BW-1:0] bcnt;
    logic [SW-1:0] scnt;

    logic rise_evt;
    logic fall_evt;
    logic boundary;

    assign rise_evt = !bus.sck && (dcnt == DCNT_MAX);
    assign fall_evt =  bus.sck && (dcnt == DCNT_MAX);
    // ws is about to return to the left slot: the end of a full frame
    assign boundary = fall_evt && (bcnt == BCNT_MAX) && bus.ws;

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state           <= IDLE;
            dcnt            <= '0;
            bcnt            <= '0;
            scnt            <= '0;
            bus.sck         <= 1'b0;
            bus.ws          <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.running     <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.frame_start <= 1'b0;
            if (state == IDLE) begin
                dcnt        <= '0;
                bcnt        <= '0;
                scnt        <= '0;
                bus.sck     <= 1'b0;
                bus.ws      <= 1'b0;
                bus.running <= 1'b0;
                bus.busy    <= bus.enable;
                if (bus.enable) begin
                    state <= STARTUP;
                end
            end else begin
                if (dcnt == DCNT_MAX) begin
                    dcnt    <= '0;
                    bus.sck <= ~bus.sck;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end

                if (fall_evt) begin
                    if (bcnt == BCNT_MAX) begin
                        bcnt   <= '0;
                        bus.ws <= ~bus.ws;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end

                if (rise_evt && (scnt != SCNT_MAX)) begin
                    scnt <= scnt + 1'b1;
                end

                case (state)
                    STARTUP: begin
                        if (!bus.enable) begin
                            state    <= IDLE;
                            dcnt     <= '0;
                            bcnt     <= '0;
                            scnt     <= '0;
                            bus.sck  <= 1'b0;
                            bus.ws   <= 1'b0;
                            bus.busy <= 1'b0;
                        end else if (boundary && (scnt == SCNT_MAX)) begin
                            state           <= RUN;
                            bus.running     <= 1'b1;
                            bus.frame_start <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (boundary) begin
                            bus.frame_start <= 1'b1;
                        end
                        if (!bus.enable) begin
                            state       <= DRAIN;
                            bus.running <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        // busy is left high here and cleared by IDLE one cycle later
                        if (boundary) begin
                            state   <= IDLE;
                            bus.sck <= 1'b0;
                            bus.ws  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2s_clock_controller.sv
// Randomized bench for i2s_clock_controller, checked every cycle against a
// time-since-start model of the I2S bus.
module tb_i2s_clock_controller;
    localparam int SCK_DIV     = 2;
    localparam int SLOT_BITS   = 4;
    localparam int STARTUP_SCK = 8;
    localparam int HALF_SLOT   = SCK_DIV * 2 * SLOT_BITS;
    localparam int FRAME       = 2 * HALF_SLOT;

    localparam int M_IDLE  = 0;
    localparam int M_START = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic m_axis_aclk;
    logic m_axis_aresetn;

    i2s_clock_controller_if bus ();

    i2s_clock_controller #(
        .SCK_DIV     (SCK_DIV),
        .SLOT_BITS   (SLOT_BITS),
        .STARTUP_SCK (STARTUP_SCK)
    ) dut (
        .m_axis_aclk    (m_axis_aclk),
        .m_axis_aresetn (m_axis_aresetn),
        .bus            (bus)
    );

    initial m_axis_aclk = 1'b0;
    always #5 m_axis_aclk = ~m_axis_aclk;

    int total = 0;
    int bad   = 0;

    int   m_mode = M_IDLE;
    int   m_t    = 0;
    logic e_sck  = 1'b0;
    logic e_ws   = 1'b0;
    logic e_fs   = 1'b0;
    logic e_run  = 1'b0;
    logic e_busy = 1'b0;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got=%b want=%b (sck ws frame_start running busy)",
                     tag, $time, observed[4:0], expected[4:0]);
        end
    endtask

    function automatic int risesBy(input int x);
        return (x / SCK_DIV + 1) / 2;
    endfunction

    function automatic logic [7:0] observedVec();
        return {3'b000, bus.sck, bus.ws, bus.frame_start, bus.running, bus.busy};
    endfunction

    function automatic logic [7:0] expectedVec();
        return {3'b000, e_sck, e_ws, e_fs, e_run, e_busy};
    endfunction

    task automatic modelReset();
        m_mode = M_IDLE;
        m_t    = 0;
        e_sck  = 1'b0;
        e_ws   = 1'b0;
        e_fs   = 1'b0;
        e_run  = 1'b0;
        e_busy = 1'b0;
    endtask

    // Bus waveform is a pure function of cycles since the first STARTUP cycle
    task automatic modelBusAt(input int t);
        e_sck = ((t / SCK_DIV) % 2) == 1;
        e_ws  = ((t / HALF_SLOT) % 2) == 1;
    endtask

    task automatic modelStep(input logic en);
        e_fs = 1'b0;
        case (m_mode)
            M_IDLE: begin
                e_sck  = 1'b0;
                e_ws   = 1'b0;
                e_run  = 1'b0;
                e_busy = en;
                if (en) begin
                    m_mode = M_START;
                    m_t    = 0;
                end
            end
            M_START: begin
                if (!en) begin
                    modelReset();
                end else begin
                    m_t++;
                    modelBusAt(m_t);
                    if ((m_t % FRAME == 0) && (risesBy(m_t - 1) >= STARTUP_SCK)) begin
                        m_mode = M_RUN;
                        e_run  = 1'b1;
                        e_fs   = 1'b1;
                    end
                end
            end
            M_RUN: begin
                m_t++;
                modelBusAt(m_t);
                e_fs = (m_t % FRAME == 0);
                if (!en) begin
                    m_mode = M_DRAIN;
                    e_run  = 1'b0;
                end
            end
            default: begin
                m_t++;
                modelBusAt(m_t);
                if (m_t % FRAME == 0) begin
                    m_mode = M_IDLE;
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input logic en, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.enable = en;
            @(posedge m_axis_aclk);
            modelStep(en);
            @(negedge m_axis_aclk);
            checkOutput("cycle", observedVec(), expectedVec());
        end
    endtask

    task automatic midRunReset();
        int budget;
        logic reached;
        budget  = 300;
        reached = 1'b0;
        while (!reached && budget > 0) begin
            applyStimulus(1'b1, 1);
            reached = (m_mode == M_RUN) && e_sck && e_ws;
            budget--;
        end
        checkOutput("rst_wait", {7'd0, reached}, 8'd1);
        #2 m_axis_aresetn = 1'b0;
        #1 modelReset();
        checkOutput("async_rst", observedVec(), expectedVec());
        for (int i = 0; i < 2; i++) begin
            @(negedge m_axis_aclk);
            checkOutput("rst_hold", observedVec(), expectedVec());
        end
        m_axis_aresetn = 1'b1;
    endtask

    initial begin
        int kind;
        m_axis_aresetn = 1'b0;
        bus.enable     = 1'b1;
        modelReset();
        for (int i = 0; i < 3; i++) begin
            @(negedge m_axis_aclk);
            checkOutput("reset", observedVec(), expectedVec());
        end
        m_axis_aresetn = 1'b1;

        // Reach RUN, stop mid-frame, abort a start-up, then restart
        applyStimulus(1'b1, 100);
        applyStimulus(1'b0, 50);
        applyStimulus(1'b1, 11);
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 80);
        applyStimulus(1'b0, 5);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 40);
        midRunReset();
        applyStimulus(1'b1, 70);

        for (int seg = 0; seg < 40; seg++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    applyStimulus(1'b1, $urandom_range(40, 150));
                    applyStimulus(1'b0, $urandom_range(1, 80));
                end
                1: begin
                    applyStimulus(1'b1, $urandom_range(1, 40));
                    applyStimulus(1'b0, $urandom_range(1, 5));
                end
                2: begin
                    for (int i = 0; i < $urandom_range(5, 60); i++) begin
                        applyStimulus(1'($urandom_range(0, 1)), 1);
                    end
                end
                default: begin
                    midRunReset();
                end
            endcase
        end
        applyStimulus(1'b0, 80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
